// File: rtl/dbg_clk_probe_if.sv
// Board-side control and CPU-side observation signals of the debug clock/probe block.
// The board or bench drives the master side; dbg_clk_probe implements the slave side.
interface dbg_clk_probe_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
);
  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic                     key_i;
  logic                     mode_i;
  logic [DIV_W-1:0]         div_i;
  logic [SEL_W-1:0]         sel_i;
  logic                     freeze_i;
  logic [NUM_CH*DATA_W-1:0] probe_i;
  logic                     cpu_ce_o;
  logic [DATA_W-1:0]        data_o;
  logic                     valid_o;
  logic [31:0]              ce_cnt_o;

  modport master (
    output key_i, mode_i, div_i, sel_i, freeze_i, probe_i,
    input  cpu_ce_o, data_o, valid_o, ce_cnt_o
  );

  modport slave (
    input  key_i, mode_i, div_i, sel_i, freeze_i, probe_i,
    output cpu_ce_o, data_o, valid_o, ce_cnt_o
  );
endinterface

// File: rtl/dbg_clk_probe.sv
// CPU clock-enable generator (divided run mode or debounced single-step) with a
// registered probe mux that samples whenever the CPU has just advanced.
module dbg_clk_probe #(
  parameter int NUM_CH       = 16,
  parameter int DATA_W       = 32,
  parameter int DIV_W        = 8,
  parameter int DEBOUNCE_CYC = 50000
) (
  input logic           clk,
  input logic           rst,
  dbg_clk_probe_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH) + 1;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STEP = 1'b1
  } mode_e;

  mode_e              state_q, state_d;
  logic               sync1_q, key_s_q;
  logic               key_db_q, key_db_d;
  logic               key_db_dly_q;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic [31:0]        ce_cnt_q, ce_cnt_d;
  logic [SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               step_req;
  logic               load;
  logic [DATA_W-1:0]  mux_out;
  logic [DATA_W-1:0]  ch [2**IDX_W];

  // Unused slots above NUM_CH read as zero, so any out-of-range sel yields 0.
  generate
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_used
        assign ch[gi] = bus.probe_i[gi*DATA_W +: DATA_W];
      end else begin : g_empty
        assign ch[gi] = '0;
      end
    end
  endgenerate

  assign mux_out  = bus.sel_i[SEL_W-1] ? '0 : ch[bus.sel_i[IDX_W-1:0]];
  assign step_req = key_db_q & ~key_db_dly_q;

  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (key_s_q != key_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        key_db_d = key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // A mode switch costs one idle cycle and swallows any coincident step request.
  always_comb begin
    state_d   = bus.mode_i ? ST_STEP : ST_RUN;
    div_cnt_d = div_cnt_q;
    cpu_ce_d  = 1'b0;
    if (state_d != state_q) begin
      div_cnt_d = '0;
    end else if (state_q == ST_STEP) begin
      div_cnt_d = '0;
      cpu_ce_d  = step_req;
    end else if (div_cnt_q >= bus.div_i) begin
      div_cnt_d = '0;
      cpu_ce_d  = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    load     = cpu_ce_q | (bus.sel_i != sel_q);
    data_d   = data_q;
    valid_d  = valid_q;
    ce_cnt_d = ce_cnt_q + {31'd0, cpu_ce_q};
    if (load && !bus.freeze_i) begin
      data_d  = mux_out;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      sync1_q      <= 1'b0;
      key_s_q      <= 1'b0;
      key_db_q     <= 1'b0;
      key_db_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      div_cnt_q    <= '0;
      cpu_ce_q     <= 1'b0;
      ce_cnt_q     <= '0;
      sel_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.key_i;
      key_s_q      <= sync1_q;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_q;
      db_cnt_q     <= db_cnt_d;
      div_cnt_q    <= div_cnt_d;
      cpu_ce_q     <= cpu_ce_d;
      ce_cnt_q     <= ce_cnt_d;
      sel_q        <= bus.sel_i;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.cpu_ce_o = cpu_ce_q;
  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.ce_cnt_o = ce_cnt_q;
endmodule

// File: tb/tb_dbg_clk_probe.sv
// Directed bench for dbg_clk_probe: expectations are queued as stimulus is applied
// and checked against the outputs at the following falling edge.
module tb_dbg_clk_probe;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 8;
  localparam int DEB    = 4;

  localparam int K_CE  = 0;
  localparam int K_DAT = 1;
  localparam int K_VAL = 2;
  localparam int K_CNT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dbg_clk_probe_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus();

  dbg_clk_probe #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input string tag, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_CE:    obs = 32'(bus.cpu_ce_o);
        K_DAT:   obs = bus.data_o;
        K_VAL:   obs = 32'(bus.valid_o);
        default: obs = bus.ce_cnt_o;
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic cyc_chk();
    @(negedge clk);
    drain();
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    bus.probe_i[k*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pulses;
    logic found;

    bus.key_i    = 1'b0;
    bus.mode_i   = 1'b0;
    bus.div_i    = 8'd3;
    bus.sel_i    = '0;
    bus.freeze_i = 1'b0;
    bus.probe_i  = '0;
    repeat (3) @(negedge clk);

    push(K_CE, "rst_ce", 0); push(K_DAT, "rst_data", 0);
    push(K_VAL, "rst_valid", 0); push(K_CNT, "rst_cnt", 0);
    cyc_chk();
    rst = 1'b1;

    // T1: div=3 gives a pulse every 4th cycle
    for (int c = 1; c <= 40; c++) begin
      push(K_CE, "t1_ce", 32'((c % 4) == 0));
      cyc_chk();
    end
    push(K_CNT, "t1_cnt", 10); push(K_VAL, "t1_valid", 1);
    cyc_chk();

    // T2: div=0 continuous, then lower div below the running count
    bus.div_i = 8'd0;
    for (int c = 0; c < 8; c++) begin
      push(K_CE, "t2_ce_div0", 1);
      cyc_chk();
    end
    bus.div_i = 8'd9;
    for (int c = 0; c < 6; c++) begin
      push(K_CE, "t2_ce_div9", 0);
      cyc_chk();
    end
    bus.div_i = 8'd2;
    for (int c = 1; c <= 7; c++) begin
      push(K_CE, "t2_ce_div2", 32'((c % 3) == 1));
      cyc_chk();
    end

    // T3: step mode with a bouncing key
    bus.mode_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push(K_CE, "t3_ce_modechg", 0);
      cyc_chk();
    end
    bus.key_i = 1'b1; push(K_CE, "t3_ce_bounce", 0); cyc_chk();
    bus.key_i = 1'b0; push(K_CE, "t3_ce_bounce", 0); cyc_chk();
    bus.key_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      push(K_CE, "t3_ce_step", 32'(c == 7));
      cyc_chk();
    end
    bus.key_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      push(K_CE, "t3_ce_release", 0);
      cyc_chk();
    end

    // T4: channel select loads
    set_ch(2, 32'hDEAD_BEEF);
    set_ch(1, 32'h0BAD_F00D);
    bus.sel_i = 3'd2;
    push(K_DAT, "t4_data_ch2", 32'hDEAD_BEEF); push(K_VAL, "t4_valid", 1);
    cyc_chk();
    bus.sel_i = 3'd5;
    push(K_DAT, "t4_data_oob", 0);
    cyc_chk();
    bus.sel_i = 3'd1;
    push(K_DAT, "t4_data_ch1", 32'h0BAD_F00D);
    cyc_chk();
    bus.sel_i = 3'd2;
    push(K_DAT, "t4_data_ch2b", 32'hDEAD_BEEF);
    cyc_chk();

    // T5: freeze blocks ce and sel loads; release loads at the next pulse
    bus.freeze_i = 1'b1;
    set_ch(2, 32'h1234_5678);
    bus.sel_i = 3'd1;
    push(K_DAT, "t5_frz_sel", 32'hDEAD_BEEF);
    cyc_chk();
    bus.sel_i  = 3'd2;
    bus.mode_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      push(K_DAT, "t5_frz_hold", 32'hDEAD_BEEF);
      cyc_chk();
      if (bus.cpu_ce_o) pulses++;
    end
    chk("t5_pulses", 32'(pulses), 3);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (bus.cpu_ce_o) found = 1'b1;
    end
    chk("t5_wait_ce1", 32'(found), 1);
    @(negedge clk);
    bus.freeze_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      push(K_DAT, "t5_rel_hold", 32'hDEAD_BEEF);
      cyc_chk();
      if (bus.cpu_ce_o) found = 1'b1;
    end
    chk("t5_wait_ce2", 32'(found), 1);
    push(K_DAT, "t5_rel_load", 32'h1234_5678);
    cyc_chk();

    // T6: one-cycle reset mid-run, then first pulse div+1 cycles later
    rst = 1'b0;
    push(K_CE, "t6_ce", 0); push(K_DAT, "t6_data", 0);
    push(K_VAL, "t6_valid", 0); push(K_CNT, "t6_cnt", 0);
    cyc_chk();
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      push(K_CE, "t6_ce_after", 32'(c == 3 || c == 6));
      push(K_CNT, "t6_cnt_after", 32'(c >= 4));
      cyc_chk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
